// File: rtl/pipelined_adder_sub.sv
// Segmented, pipelined add/subtract unit with a valid/ready handshake.
// Each stage adds one SEG-bit slice; the final stage register drives the outputs.
module pipelined_adder_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             in_carry,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_overflow
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // One pipeline slot: operands travel whole so the sign bits reach the last stage.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
    } slot_t;

    if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder_sub: STAGES must be 1..8 and divide WIDTH");
    end

    slot_t entry;
    slot_t pipe [STAGES];
    slot_t nxt  [STAGES];
    logic  en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + 1, so carry-in is forced high and in_carry is ignored.
    always_comb begin
        entry.valid = in_valid;
        entry.a     = in_1;
        entry.b     = op_sub ? ~in_2 : in_2;
        entry.sum   = '0;
        entry.carry = op_sub | in_carry;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        slot_t          src;
        slot_t          res;
        logic [SEG:0]   seg_sum;

        if (k == 0) begin : g_first
            assign src = entry;
        end else begin : g_next
            assign src = pipe[k-1];
        end

        assign seg_sum = {1'b0, src.a[LO +: SEG]} + {1'b0, src.b[LO +: SEG]}
                       + {{SEG{1'b0}}, src.carry};

        // NOTE: res takes src as a full default before the slice update, so no latch is inferred.
        always_comb begin
            res                = src;
            res.sum[LO +: SEG] = seg_sum[SEG-1:0];
            res.carry          = seg_sum[SEG];
        end

        assign nxt[k] = res;
    end

    // NOTE: data registers are reset along with valid bits so out_sum reads 0 after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
        end else if (en) begin
            for (int k = 0; k < LAST; k++) pipe[k] <= nxt[k];
            // Output data only moves on a valid result; bubbles just clear out_valid.
            if (nxt[LAST].valid) pipe[LAST] <= nxt[LAST];
            else                 pipe[LAST].valid <= 1'b0;
        end
    end

    assign out_valid    = pipe[LAST].valid;
    assign out_sum      = {pipe[LAST].carry, pipe[LAST].sum};
    assign out_overflow = (pipe[LAST].a[WIDTH-1] == pipe[LAST].b[WIDTH-1])
                       && (pipe[LAST].sum[WIDTH-1] != pipe[LAST].a[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Scoreboard bench for pipelined_adder_sub: three configurations (32/2, 64/4, 8/1)
// share one stimulus stream; the 32/2 instance also sees backpressure and reset.
module tb_pipelined_adder_sub;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin      = 1'b0;
    logic        sub      = 1'b0;
    logic [63:0] a        = '0;
    logic [63:0] b        = '0;
    logic        ordy0    = 1'b1;
    logic        ordy_aux = 1'b1;

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
    logic [32:0] os0;
    logic [64:0] os1;
    logic [8:0]  os2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t;
    bit lat_en0 = 1'b1;

    logic [65:0] q0[$], q1[$], q2[$];
    int          c0[$], c1[$], c2[$];

    pipelined_adder_sub #(.WIDTH(32), .STAGES(2)) u_dut32 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_1(a[31:0]), .in_2(b[31:0]), .in_carry(cin), .op_sub(sub),
        .out_valid(ov0), .out_ready(ordy0), .out_sum(os0), .out_overflow(of0));

    pipelined_adder_sub #(.WIDTH(64), .STAGES(4)) u_dut64 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_1(a), .in_2(b), .in_carry(cin), .op_sub(sub),
        .out_valid(ov1), .out_ready(ordy_aux), .out_sum(os1), .out_overflow(of1));

    pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .in_1(a[7:0]), .in_2(b[7:0]), .in_carry(cin), .op_sub(sub),
        .out_valid(ov2), .out_ready(ordy_aux), .out_sum(os2), .out_overflow(of2));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word-level reference: {overflow, carry_out, zero-extended w-bit sum}.
    function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic s, input int w);
        logic [63:0] mask, xa, yb;
        logic [64:0] r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        xa   = x & mask;
        yb   = (s ? ~y : y) & mask;
        r    = {1'b0, xa} + {1'b0, yb} + {64'd0, (s | c)};
        return {(xa[w-1] == yb[w-1]) && (r[w-1] != xa[w-1]), r[w], r[63:0] & mask};
    endfunction

    function automatic logic [65:0] got0();
        return {of0, os0[32], 32'd0, os0[31:0]};
    endfunction

    // Scoreboard: push on accept, pop and compare on each output transfer.
    always @(negedge clock) begin
        if (reset) begin
            if (in_valid && rdy0) begin q0.push_back(model(a, b, cin, sub, 32)); c0.push_back(cyc); end
            if (in_valid && rdy1) begin q1.push_back(model(a, b, cin, sub, 64)); c1.push_back(cyc); end
            if (in_valid && rdy2) begin q2.push_back(model(a, b, cin, sub, 8));  c2.push_back(cyc); end
            if (ov0 && ordy0) begin
                if (q0.size() == 0) check("d32_unexpected_out", 66'(ov0), 66'd0);
                else begin
                    check("d32_result", got0(), q0.pop_front());
                    t = c0.pop_front();
                    if (lat_en0) check("d32_latency", 66'(cyc - t), 66'd2);
                end
            end
            if (ov1 && ordy_aux) begin
                if (q1.size() == 0) check("d64_unexpected_out", 66'(ov1), 66'd0);
                else begin
                    check("d64_result", {of1, os1}, q1.pop_front());
                    t = c1.pop_front();
                    check("d64_latency", 66'(cyc - t), 66'd4);
                end
            end
            if (ov2 && ordy_aux) begin
                if (q2.size() == 0) check("d8_unexpected_out", 66'(ov2), 66'd0);
                else begin
                    check("d8_result", {of2, os2[8], 56'd0, os2[7:0]}, q2.pop_front());
                    t = c2.pop_front();
                    check("d8_latency", 66'(cyc - t), 66'd1);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted.
    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
        int n = 0;
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        @(negedge clock);
        while (!rdy0 && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (n == 64) check("accept_timeout", 66'(rdy0), 66'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain_left", 66'(q0.size() + q1.size() + q2.size()), 66'd0);
        @(posedge clock); #1;
    endtask

    logic [65:0] exp2;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 66'(ov0), 66'd0);
        check("rst_out_sum", 66'(os0), 66'd0);
        check("rst_out_overflow", 66'(of0), 66'd0);
        check("rst_out_valid_d64", 66'(ov1), 66'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 66'(rdy0), 66'd1);
        @(posedge clock); #1;

        // Directed corners: segment carry, borrow, signed overflow, carry-in.
        send(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
        send(64'd5, 64'd7, 1'b0, 1'b1);
        send(64'd7, 64'd5, 1'b0, 1'b1);
        send(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
        send(64'h8000_0000, 64'h1, 1'b0, 1'b1);
        send(64'h0000_FFFF, 64'h0, 1'b1, 1'b0);
        send(64'd10, 64'd3, 1'b1, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 16; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        drain();

        // Backpressure: stall the 32-bit unit with its second result at the output.
        lat_en0 = 1'b0;
        send(64'd100, 64'd1, 1'b0, 1'b0);
        send(64'd200, 64'd2, 1'b0, 1'b1);
        send(64'd300, 64'd3, 1'b1, 1'b0);
        ordy0 = 1'b0;
        exp2  = model(64'd200, 64'd2, 1'b0, 1'b1, 32);
        fork
            send(64'd400, 64'd4, 1'b0, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clock);
                    check("bp_in_ready", 66'(rdy0), 66'd0);
                    check("bp_out_valid", 66'(ov0), 66'd1);
                    check("bp_held_result", got0(), exp2);
                end
                @(posedge clock); #1;
                ordy0 = 1'b1;
            end
        join
        drain();
        lat_en0 = 1'b1;

        // Asynchronous reset with transactions in flight.
        send(64'd11, 64'd22, 1'b0, 1'b0);
        send(64'd33, 64'd44, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        c0.delete(); c1.delete(); c2.delete();
        #1;
        check("async_rst_out_valid", 66'(ov0), 66'd0);
        check("async_rst_out_sum", 66'(os0), 66'd0);
        check("async_rst_out_valid_d64", 66'(ov1), 66'd0);
        check("async_rst_out_valid_d8", 66'(ov2), 66'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("post_rst_idle", 66'(ov0), 66'd0);
        end
        @(posedge clock); #1;
        send(64'd55, 64'd66, 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
Parametrised, segmented, pipelined add/subtract unit. It is the general successor to the fixed 32-bit two-stage adder: operand width and stage count are set by parameters. It adds a per-transaction subtract mode, carry-in, a signed-overflow flag and a valid/ready handshake with backpressure. It sits between operand producers and accumulator/ALU consumers that need high clock rates.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of STAGES.
STAGES, 2, number of pipeline segments (1..8); segment width SEG = WIDTH/STAGES.

Ports:
clock  input  1  rising-edge clock for all state.
reset  input  1  asynchronous, active-low reset; clears all state while low.
in_valid  input  1  operand transaction valid.
in_ready  output  1  unit accepts a transaction this cycle.
in_1  input  WIDTH  operand A.
in_2  input  WIDTH  operand B.
in_carry  input  1  carry-in for add mode; ignored in subtract mode.
op_sub  input  1  0 = A+B+in_carry; 1 = A-B (A + ~B + 1).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result this cycle.
out_sum  output  WIDTH+1  {carry_out, sum}; in subtract mode bit WIDTH = NOT borrow.
out_overflow  output  1  signed two's-complement overflow of the WIDTH-bit result.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits, out_valid, out_sum and out_overflow go to 0. All pipeline data registers go to 0. On release, in_ready=1.
- Global enable: en = !out_valid || out_ready; in_ready = en (combinational). When en=0, every pipeline register holds its value.
- Accept: a transaction enters when in_valid && in_ready. Stage-0 valid <= in_valid when en.
- Operand conditioning at entry: B' = op_sub ? ~in_2 : in_2; cin = op_sub ? 1 : in_carry.
- Stage k (k = 0..STAGES-1):
  - Adds segment k of A and B' with the carry registered from stage k-1; stage 0 uses cin.
  - Registers its SEG-bit partial sum and its carry.
  - Forwards the upper, not-yet-added operand segments.
  - Forwards the already-computed lower sum bits (skew alignment), so all segments of one transaction emerge together.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready is held 1. Throughput: 1 result per cycle, no bubbles inserted.
- Output on the final stage: out_sum = {carry_out, sum}. out_overflow = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]). The sign bits are carried through the pipeline for this calculation.
- STAGES=1: a single registered adder with latency 1; the handshake is unchanged.
- Backpressure: while out_valid=1 and out_ready=0, out_sum, out_overflow and out_valid are held stable and no transaction is accepted. When out_ready rises, data resumes with no loss or duplication.
- Bubbles: invalid slots advance with en like valid ones. Their data contents are don't-care, but out_sum is registered only from a valid slot, so output data changes only with valid results.
- Wrap-around: A+B overflow beyond WIDTH appears only in out_sum[WIDTH]; the sum wraps modulo 2^WIDTH.
- Reset mid-operation: all in-flight transactions are discarded and no stale out_valid appears after release.
- Illegal parameters (WIDTH % STAGES != 0) are flagged by an elaboration-time check.

Test Plan:
- Carry across the segment boundary (W=32, S=2): A=0xFFFFFFFF, B=0x1, op_sub=0, cin=0 -> 2 cycles later out_valid=1, out_sum=0x1_00000000, out_overflow=0.
- Subtract with borrow: A=5, B=7, op_sub=1 -> out_sum=0x0_FFFFFFFE (bit32=0, borrow), out_overflow=0. Then A=7, B=5 -> out_sum=0x1_00000002.
- Signed overflow: A=0x7FFFFFFF, B=1 add -> out_overflow=1. A=0x80000000, B=1 sub -> out_overflow=1, out_sum[31:0]=0x7FFFFFFF.
- Back-to-back streaming: 16 random transactions with in_valid=1 and out_ready=1 -> 16 consecutive results in order, each matching the reference model, first result at cycle 2. Repeat with W=64, S=4 (latency 4) and W=8, S=1 (latency 1).
- Backpressure: 3 transactions accepted, then out_ready=0 for 5 cycles -> in_ready=0 and out_sum held. When out_ready=1, the remaining results drain in order, none lost or duplicated.
- Asynchronous reset mid-stream: assert reset=0 between clock edges with 2 transactions in flight -> out_valid=0 and out_sum=0 immediately. After release, no result appears until a new transaction is accepted.
